// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO and registered result stage wrapped around an
// external 16-bit combinational ALU. Commands are queued DEPTH deep, the head
// entry drives the ALU through alu_*, and each result is captured into an
// output register that drains over a valid/ready handshake.
//
// Optional build macro: ALU_ACC_EN
//   defined   - each entry carries use_acc; an accumulator tracks the last
//               captured result and replaces A for entries with use_acc=1.
//   undefined - no accumulator; in_use_acc is ignored.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | queue empty, nothing to issue
// EXEC  | head valid and output register free: capture ALU result, pop
// STALL | head valid but held result not yet accepted downstream
module alu_cmd_queue #(
  parameter int N      = 16,
  parameter int MODE_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  input  logic                       in_cin,
  input  logic [MODE_W-1:0]          in_mode,
  input  logic                       in_use_acc,
  output logic [N-1:0]               alu_a,
  output logic [N-1:0]               alu_b,
  output logic                       alu_cin,
  output logic [MODE_W-1:0]          alu_mode,
  input  logic [N-1:0]               alu_y,
  input  logic                       alu_cout,
  input  logic                       alu_ovf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_y,
  output logic                       out_cout,
  output logic                       out_ovf,
  output logic [MODE_W-1:0]          out_mode,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state;

  logic [N-1:0]      mem_a    [DEPTH];
  logic [N-1:0]      mem_b    [DEPTH];
  logic              mem_cin  [DEPTH];
  logic [MODE_W-1:0] mem_mode [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;
  logic          arith_mode;
  logic [N-1:0]  head_a;

`ifdef ALU_ACC_EN
  logic          mem_use_acc [DEPTH];
  logic [N-1:0]  acc;
`else
  logic          unused_use_acc;
  assign unused_use_acc = in_use_acc;
`endif

  // Full queue never accepts, even when the head is popped in the same cycle.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign empty    = (count == '0);
  assign pop      = (state == EXEC);

  // State is derived every cycle from occupancy and output-register status so
  // a freshly pushed command can issue on the very next edge.
  always_comb begin
    state = IDLE;
    if (!empty) begin
      if (out_valid && !out_ready) state = STALL;
      else                         state = EXEC;
    end
  end

  // Operand A source: stored A, or the accumulator when the entry asks for it.
  always_comb begin
`ifdef ALU_ACC_EN
    head_a = mem_use_acc[rd_ptr] ? acc : mem_a[rd_ptr];
`else
    head_a = mem_a[rd_ptr];
`endif
  end

  // Head entry drives the ALU; an empty queue presents all-zero operands.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_mode = '0;
    if (!empty) begin
      alu_a    = head_a;
      alu_b    = mem_b[rd_ptr];
      alu_cin  = mem_cin[rd_ptr];
      alu_mode = mem_mode[rd_ptr];
    end
  end

  // Carry/overflow are only meaningful for add (4) and subtract (5).
  assign arith_mode = (alu_mode == MODE_W'(4)) || (alu_mode == MODE_W'(5));

  // Command storage; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]    <= in_a;
      mem_b[wr_ptr]    <= in_b;
      mem_cin[wr_ptr]  <= in_cin;
      mem_mode[wr_ptr] <= in_mode;
`ifdef ALU_ACC_EN
      mem_use_acc[wr_ptr] <= in_use_acc;
`endif
    end
  end

  // Pointers, occupancy, result register and accumulator, sequenced by state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_mode  <= '0;
`ifdef ALU_ACC_EN
      acc       <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);

      case (state)
        EXEC: begin
          out_y     <= alu_y;
          out_mode  <= alu_mode;
          out_cout  <= arith_mode & alu_cout;
          out_ovf   <= arith_mode & alu_ovf;
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + PW'(1);
`ifdef ALU_ACC_EN
          acc       <= alu_y;
`endif
        end
        STALL: begin
          // result held until the consumer takes it
        end
        default: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
      endcase

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
